// File: rtl/tipi_nib_xfer.sv
// Pi-side latch shuttle: NCH channel latches written directly by the TI side and
// moved to/from the Raspberry Pi as NIB_W-bit nibbles, MSB nibble first.
module tipi_nib_xfer #(
   parameter int DATA_W = 8,
   parameter int NIB_W  = 4,
   parameter int NCH    = 4,
   localparam int BEATS = DATA_W / NIB_W,
   localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                  r_clk,
   input  logic                  r_reset,
   input  logic                  r_nibrst,
   input  logic                  start,
   input  logic                  dir,
   input  logic [CW-1:0]         ch_sel,
   input  logic [NIB_W-1:0]      nib_in,
   output logic [NIB_W-1:0]      nib_out,
   output logic                  nib_oe,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   input  logic [NCH-1:0]        ti_wr,
   input  logic [DATA_W-1:0]     ti_d,
   output logic [NCH*DATA_W-1:0] lat_q,
   output logic [NCH-1:0]        chg
);

   localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t              state;
   logic [BW-1:0]       beat;
   logic [DATA_W-1:0]   shreg;
   logic                xdir;
   logic [CW-1:0]       xch;
   logic [DATA_W-1:0]   lat [NCH];

   logic                ti_any;
   logic [CW-1:0]       ti_ch;
   logic [DATA_W-1:0]   rd_snap;
   logic                ch_ok;
   logic                last_beat;
   logic                pi_wr_commit;
   logic                pi_rd_commit;
   logic                collide;
   logic [DATA_W-1:0]   shift_rd;
   logic [DATA_W-1:0]   shift_in;

   // Handshake: start (with dir/ch_sel) is taken only in IDLE; busy covers the
   // BEATS shift edges; done is a single-cycle pulse after the last beat, and a
   // new start is legal on that done cycle.

   // Lowest-index TI strobe wins when several are set.
   always_comb begin
      ti_any = 1'b0;
      ti_ch  = '0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (ti_wr[c]) begin
            ti_any = 1'b1;
            ti_ch  = CW'(c);
         end
      end
   end

   always_comb begin
      rd_snap = '0;
      for (int c = 0; c < NCH; c++) begin
         if (ch_sel == CW'(c)) rd_snap = lat[c];
      end
   end

   always_comb begin
      lat_q = '0;
      for (int c = 0; c < NCH; c++) begin
         lat_q[c*DATA_W +: DATA_W] = lat[c];
      end
   end

   assign ch_ok        = (32'(ch_sel) < 32'(NCH));
   assign last_beat    = (state == SHIFT) && (beat == BW'(BEATS - 1));
   assign pi_wr_commit = last_beat && xdir && !r_nibrst;
   assign pi_rd_commit = last_beat && !xdir && !r_nibrst;
   assign collide      = pi_wr_commit && ti_any && (ti_ch == xch);
   assign shift_rd     = shreg << NIB_W;
   assign shift_in     = (shreg << NIB_W) | DATA_W'(nib_in);
   assign busy         = (state == SHIFT);

   // A TI write always beats a Pi write completing on the same edge.
   always_ff @(posedge r_clk or negedge r_reset) begin
      if (!r_reset) begin
         for (int c = 0; c < NCH; c++) lat[c] <= '0;
         chg <= '0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (ti_any && (ti_ch == CW'(c))) begin
               lat[c] <= ti_d;
               chg[c] <= 1'b1;
            end else begin
               if (pi_wr_commit && (xch == CW'(c))) lat[c] <= shift_in;
               if (pi_rd_commit && (xch == CW'(c))) chg[c] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge r_clk or negedge r_reset) begin
      if (!r_reset) begin
         state   <= IDLE;
         beat    <= '0;
         shreg   <= '0;
         xdir    <= 1'b0;
         xch     <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
         nib_out <= '0;
         nib_oe  <= 1'b0;
      end else begin
         done    <= 1'b0;
         err     <= 1'b0;
         nib_out <= '0;
         nib_oe  <= 1'b0;
         if (r_nibrst) begin
            state <= IDLE;
            beat  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (ch_ok) begin
                        state <= SHIFT;
                        beat  <= '0;
                        xdir  <= dir;
                        xch   <= ch_sel;
                        shreg <= dir ? '0 : rd_snap;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               SHIFT: begin
                  if (start) err <= 1'b1;
                  if (xdir) begin
                     shreg <= shift_in;
                  end else begin
                     shreg   <= shift_rd;
                     nib_out <= shreg[DATA_W-1 -: NIB_W];
                     nib_oe  <= 1'b1;
                  end
                  if (last_beat) begin
                     state <= IDLE;
                     beat  <= '0;
                     done  <= 1'b1;
                     if (collide) err <= 1'b1;
                  end else begin
                     beat <= beat + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tipi_nib_xfer.sv
// Bench for tipi_nib_xfer: default instance (a), NCH=3 instance (b) and a
// DATA_W=16 instance (c) share the clock, reset, abort and transfer controls.
module tb_tipi_nib_xfer;

   logic        r_clk = 1'b0;
   logic        r_reset = 1'b0;
   logic        r_nibrst = 1'b0;
   logic        dir = 1'b0;
   logic [1:0]  ch_sel = '0;
   logic [3:0]  nib_in = '0;

   logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic [3:0]  ti_wr_a = '0;
   logic [2:0]  ti_wr_b = '0;
   logic [3:0]  ti_wr_c = '0;
   logic [7:0]  ti_d_a = '0, ti_d_b = '0;
   logic [15:0] ti_d_c = '0;

   logic [3:0]  nib_out_a, nib_out_b, nib_out_c;
   logic        nib_oe_a, nib_oe_b, nib_oe_c;
   logic        busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c;
   logic        err_a, err_b, err_c;
   logic [31:0] lat_q_a;
   logic [23:0] lat_q_b;
   logic [63:0] lat_q_c;
   logic [3:0]  chg_a, chg_c;
   logic [2:0]  chg_b;

   int tests_run = 0;
   int tests_failed = 0;

   logic [3:0]  exp_q[$];
   logic [15:0] exp_d_q[$];
   logic [3:0]  exp_n;
   logic [15:0] exp_d;

   tipi_nib_xfer u_a (
      .r_clk(r_clk), .r_reset(r_reset), .r_nibrst(r_nibrst), .start(start_a),
      .dir(dir), .ch_sel(ch_sel), .nib_in(nib_in), .nib_out(nib_out_a),
      .nib_oe(nib_oe_a), .busy(busy_a), .done(done_a), .err(err_a),
      .ti_wr(ti_wr_a), .ti_d(ti_d_a), .lat_q(lat_q_a), .chg(chg_a));

   tipi_nib_xfer #(.NCH(3)) u_b (
      .r_clk(r_clk), .r_reset(r_reset), .r_nibrst(r_nibrst), .start(start_b),
      .dir(dir), .ch_sel(ch_sel), .nib_in(nib_in), .nib_out(nib_out_b),
      .nib_oe(nib_oe_b), .busy(busy_b), .done(done_b), .err(err_b),
      .ti_wr(ti_wr_b), .ti_d(ti_d_b), .lat_q(lat_q_b), .chg(chg_b));

   tipi_nib_xfer #(.DATA_W(16)) u_c (
      .r_clk(r_clk), .r_reset(r_reset), .r_nibrst(r_nibrst), .start(start_c),
      .dir(dir), .ch_sel(ch_sel), .nib_in(nib_in), .nib_out(nib_out_c),
      .nib_oe(nib_oe_c), .busy(busy_c), .done(done_c), .err(err_c),
      .ti_wr(ti_wr_c), .ti_d(ti_d_c), .lat_q(lat_q_c), .chg(chg_c));

   // clock / reset
   always #5 r_clk = ~r_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge r_clk);
      #1;
   endtask

   task automatic test_reset();
      r_reset = 1'b0;
      start_a = 1'b1;
      ti_wr_a = 4'b1111;
      ti_d_a  = 8'hFF;
      step();
      step();
      tests_run++;
      if (lat_q_a !== 32'h0) begin tests_failed++; $display("FAIL reset_lat: got %h want 0", lat_q_a); end
      tests_run++;
      if ({chg_a, busy_a, done_a, err_a, nib_oe_a} !== 8'h0) begin
         tests_failed++;
         $display("FAIL reset_outs: chg=%b busy=%b done=%b err=%b oe=%b want all 0", chg_a, busy_a, done_a, err_a, nib_oe_a);
      end
      start_a = 1'b0;
      ti_wr_a = '0;
      r_reset = 1'b1;
      step();
      tests_run++;
      if ({busy_a, done_a, err_a} !== 3'b000) begin tests_failed++; $display("FAIL reset_idle: busy/done/err=%b want 000", {busy_a, done_a, err_a}); end
   endtask

   task automatic test_read();
      int done_at;
      ti_wr_a = 4'b0010;
      ti_d_a  = 8'hAA;
      step();
      ti_wr_a = '0;
      tests_run++;
      if (chg_a !== 4'b0010) begin tests_failed++; $display("FAIL read_chg_set: got %b want 0010", chg_a); end
      tests_run++;
      if (lat_q_a[15:8] !== 8'hAA) begin tests_failed++; $display("FAIL read_ti_lat: got %h want aa", lat_q_a[15:8]); end
      exp_q.push_back(4'hA);
      exp_q.push_back(4'hA);
      start_a = 1'b1; dir = 1'b0; ch_sel = 2'd1;
      step();
      start_a = 1'b0;
      tests_run++;
      if (busy_a !== 1'b1 || nib_oe_a !== 1'b0) begin tests_failed++; $display("FAIL read_start: busy=%b oe=%b want 1 0", busy_a, nib_oe_a); end
      done_at = -1;
      for (int cyc = 1; cyc <= 8 && done_at < 0; cyc++) begin
         step();
         if (nib_oe_a) begin
            if (exp_q.size() == 0) begin
               tests_run++; tests_failed++;
               $display("FAIL read_extra_nib: got %h want none", nib_out_a);
            end else begin
               exp_n = exp_q.pop_front();
               tests_run++;
               if (nib_out_a !== exp_n) begin tests_failed++; $display("FAIL read_nib: got %h want %h", nib_out_a, exp_n); end
            end
         end
         if (done_a) done_at = cyc;
      end
      tests_run++;
      if (done_at != 2) begin tests_failed++; $display("FAIL read_done_at: got %0d want 2", done_at); end
      tests_run++;
      if (exp_q.size() != 0) begin tests_failed++; $display("FAIL read_missing_nib: got %0d left want 0", exp_q.size()); exp_q.delete(); end
      tests_run++;
      if (busy_a !== 1'b0 || chg_a !== 4'b0000) begin tests_failed++; $display("FAIL read_end: busy=%b chg=%b want 0 0000", busy_a, chg_a); end
      step();
      tests_run++;
      if (done_a !== 1'b0 || nib_oe_a !== 1'b0) begin tests_failed++; $display("FAIL read_pulse: done=%b oe=%b want 0 0", done_a, nib_oe_a); end
   endtask

   task automatic test_write();
      exp_d_q.push_back(16'h005C);
      start_a = 1'b1; dir = 1'b1; ch_sel = 2'd2;
      step();
      start_a = 1'b0;
      nib_in = 4'h5;
      step();
      tests_run++;
      if (busy_a !== 1'b1 || nib_oe_a !== 1'b0 || nib_out_a !== 4'h0) begin
         tests_failed++; $display("FAIL write_mid: busy=%b oe=%b nib=%h want 1 0 0", busy_a, nib_oe_a, nib_out_a);
      end
      nib_in = 4'hC;
      step();
      exp_d = exp_d_q.pop_front();
      tests_run++;
      if (lat_q_a[23:16] !== exp_d[7:0]) begin tests_failed++; $display("FAIL write_lat: got %h want %h", lat_q_a[23:16], exp_d[7:0]); end
      tests_run++;
      if (done_a !== 1'b1 || busy_a !== 1'b0 || chg_a[2] !== 1'b0 || err_a !== 1'b0) begin
         tests_failed++; $display("FAIL write_end: done=%b busy=%b chg2=%b err=%b want 1 0 0 0", done_a, busy_a, chg_a[2], err_a);
      end
      step();
   endtask

   task automatic test_errors();
      start_b = 1'b1; dir = 1'b0; ch_sel = 2'd3;
      step();
      start_b = 1'b0;
      tests_run++;
      if (err_b !== 1'b1 || busy_b !== 1'b0) begin tests_failed++; $display("FAIL err_badch: err=%b busy=%b want 1 0", err_b, busy_b); end
      step();
      tests_run++;
      if (err_b !== 1'b0) begin tests_failed++; $display("FAIL err_width: err=%b want 0", err_b); end
      ti_wr_b = 3'b001; ti_d_b = 8'h3C;
      step();
      ti_wr_b = '0;
      exp_q.push_back(4'h3);
      exp_q.push_back(4'hC);
      start_b = 1'b1; ch_sel = 2'd0;
      step();
      ch_sel = 2'd2;
      step();
      start_b = 1'b0;
      tests_run++;
      if (err_b !== 1'b1) begin tests_failed++; $display("FAIL err_busy_start: err=%b want 1", err_b); end
      for (int cyc = 0; cyc < 2; cyc++) begin
         if (cyc == 1) step();
         exp_n = exp_q.pop_front();
         tests_run++;
         if (nib_oe_b !== 1'b1 || nib_out_b !== exp_n) begin
            tests_failed++; $display("FAIL err_read_nib: oe=%b nib=%h want 1 %h", nib_oe_b, nib_out_b, exp_n);
         end
      end
      tests_run++;
      if (done_b !== 1'b1 || err_b !== 1'b0 || chg_b !== 3'b000) begin
         tests_failed++; $display("FAIL err_read_end: done=%b err=%b chg=%b want 1 0 000", done_b, err_b, chg_b);
      end
      step();
      tests_run++;
      if (busy_b !== 1'b0 || done_b !== 1'b0) begin tests_failed++; $display("FAIL err_no_restart: busy=%b done=%b want 0 0", busy_b, done_b); end
   endtask

   task automatic test_abort_collision();
      ti_wr_a = 4'b0001; ti_d_a = 8'h11;
      step();
      ti_wr_a = '0;
      start_a = 1'b1; dir = 1'b1; ch_sel = 2'd0;
      step();
      start_a = 1'b0;
      nib_in = 4'h9;
      step();
      r_nibrst = 1'b1;
      nib_in = 4'h8;
      step();
      r_nibrst = 1'b0;
      tests_run++;
      if (busy_a !== 1'b0 || done_a !== 1'b0 || lat_q_a[7:0] !== 8'h11) begin
         tests_failed++; $display("FAIL abort: busy=%b done=%b lat0=%h want 0 0 11", busy_a, done_a, lat_q_a[7:0]);
      end
      step();
      tests_run++;
      if (done_a !== 1'b0 || chg_a[0] !== 1'b1) begin tests_failed++; $display("FAIL abort_after: done=%b chg0=%b want 0 1", done_a, chg_a[0]); end
      start_a = 1'b1; dir = 1'b1; ch_sel = 2'd3;
      step();
      start_a = 1'b0;
      nib_in = 4'h5;
      step();
      nib_in = 4'hC;
      ti_wr_a = 4'b1000; ti_d_a = 8'h77;
      step();
      ti_wr_a = '0;
      tests_run++;
      if (lat_q_a[31:24] !== 8'h77) begin tests_failed++; $display("FAIL collide_lat: got %h want 77", lat_q_a[31:24]); end
      tests_run++;
      if (err_a !== 1'b1 || chg_a[3] !== 1'b1 || done_a !== 1'b1) begin
         tests_failed++; $display("FAIL collide_flags: err=%b chg3=%b done=%b want 1 1 1", err_a, chg_a[3], done_a);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] d;
      int done_at;
      for (int rep = 0; rep < 3; rep++) begin
         d = 8'($urandom_range(0, 255));
         exp_q.push_back(d[7:4]);
         exp_q.push_back(d[3:0]);
         start_a = 1'b1; dir = 1'b1; ch_sel = 2'd1;
         step();
         start_a = 1'b0;
         nib_in = d[7:4];
         step();
         nib_in = d[3:0];
         step();
         tests_run++;
         if (done_a !== 1'b1) begin tests_failed++; $display("FAIL b2b_wdone: done=%b want 1", done_a); end
         start_a = 1'b1; dir = 1'b0;
         step();
         start_a = 1'b0;
         done_at = -1;
         for (int cyc = 1; cyc <= 8 && done_at < 0; cyc++) begin
            step();
            if (nib_oe_a && exp_q.size() != 0) begin
               exp_n = exp_q.pop_front();
               tests_run++;
               if (nib_out_a !== exp_n) begin tests_failed++; $display("FAIL b2b_nib: got %h want %h", nib_out_a, exp_n); end
            end
            if (done_a) done_at = cyc;
         end
         tests_run++;
         if (done_at != 2 || exp_q.size() != 0) begin
            tests_failed++; $display("FAIL b2b_read: done_at=%0d left=%0d want 2 0", done_at, exp_q.size());
            exp_q.delete();
         end
      end
      step();
   endtask

   task automatic test_width();
      int done_at, first_at;
      ti_wr_c = 4'b0001; ti_d_c = 16'h1234;
      step();
      ti_wr_c = '0;
      exp_q.push_back(4'h1); exp_q.push_back(4'h2);
      exp_q.push_back(4'h3); exp_q.push_back(4'h4);
      start_c = 1'b1; dir = 1'b0; ch_sel = 2'd0;
      step();
      start_c = 1'b0;
      done_at = -1;
      first_at = -1;
      for (int cyc = 1; cyc <= 10 && done_at < 0; cyc++) begin
         step();
         if (nib_oe_c) begin
            if (first_at < 0) first_at = cyc;
            if (exp_q.size() != 0) begin
               exp_n = exp_q.pop_front();
               tests_run++;
               if (nib_out_c !== exp_n) begin tests_failed++; $display("FAIL width_nib: got %h want %h", nib_out_c, exp_n); end
            end
         end
         if (done_c) done_at = cyc;
      end
      tests_run++;
      if (first_at != 1 || done_at != 4) begin tests_failed++; $display("FAIL width_timing: first=%0d done=%0d want 1 4", first_at, done_at); end
      tests_run++;
      if (exp_q.size() != 0 || chg_c !== 4'b0000) begin
         tests_failed++; $display("FAIL width_end: left=%0d chg=%b want 0 0000", exp_q.size(), chg_c);
         exp_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_errors();
      test_abort_collision();
      test_back_to_back();
      test_width();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/tipi_nib_xfer.md
# tipi_nib_xfer

Parametrised Pi-side latch shuttle: holds NCH channel latches (TD/TC/RD/RC generalised) of DATA_W bits each, and moves them to or from the Raspberry Pi as NIB_W-bit nibbles.
- TI side writes latches directly, one channel per cycle.
- Pi side runs a start/busy/done transfer sequenced by a shift state machine.
- Per-channel change flags tell the Pi which latches the TI has written since the last Pi read.
- Sits between the TI bus decode logic and the r_nib pins in the top level.

## Interface
Parameters:
- DATA_W, 8, latch width in bits; must be a multiple of NIB_W.
- NIB_W, 4, nibble bus width.
- NCH, 4, number of channel latches, ≥1.
- BEATS (derived, not overridable) = DATA_W/NIB_W.
- CW (derived) = max(1, clog2(NCH)).

Ports:
- r_clk  in  1  sole clock, rising edge.
- r_reset  in  1  reset, asynchronous, active-low.
- r_nibrst  in  1  synchronous transfer abort, active-high.
- start  in  1  begin transfer; sampled only in IDLE.
- dir  in  1  0 = Pi reads latch, 1 = Pi writes latch; sampled with start.
- ch_sel  in  CW  channel for transfer; sampled with start.
- nib_in  in  NIB_W  nibble from Pi (write transfers).
- nib_out  out  NIB_W  nibble to Pi (read transfers).
- nib_oe  out  1  drive enable for nib_out.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle protocol error pulse.
- ti_wr  in  NCH  one-hot TI write strobe; multiple bits set → lowest index wins.
- ti_d  in  DATA_W  TI write data.
- lat_q  out  NCH*DATA_W  all latch contents; channel c at bits [c*DATA_W +: DATA_W].
- chg  out  NCH  channel written by TI since last completed Pi read.

## Operation
- **States:** IDLE, SHIFT. Internal registers:
  - beat counter, 0..BEATS-1.
  - DATA_W shift register; nibble order is MSB nibble first.
  - latched dir and ch_sel.
- **IDLE + start + valid ch_sel:** go to SHIFT, beat=0.
  - Read: shift register loads a snapshot of the selected latch.
  - Write: shift register cleared.
- **IDLE + start + ch_sel ≥ NCH:** err pulses; remain IDLE.
- **SHIFT, read:**
  - nib_out = top nibble of shift register; nib_oe=1.
  - Each edge shifts left by NIB_W and increments beat.
- **SHIFT, write:**
  - Each edge shifts nib_in into the LSBs and increments beat.
  - nib_oe=0, nib_out=0.
- **SHIFT, beat==BEATS-1 edge:** return to IDLE; done pulses next cycle.
  - Write: latch[ch] ← final shift value.
  - Read: chg[ch] cleared, unless a TI write to ch occurs on that same edge (then chg stays set).
- **TI write:** any cycle, any state. latch[c] ← ti_d and chg[c] ← 1.
- **Collisions:**
  - TI write to a channel during a Pi read of it: the read returns the snapshot, chg stays set.
  - TI write on the same edge as a Pi write completion to the same channel: TI data kept, Pi data discarded, err pulses.
- **start while busy:** ignored; err pulses; transfer continues unaffected.
- **r_nibrst:** overrides everything except r_reset.
  - State → IDLE, beat=0, no latch update, no done.
  - chg unchanged; TI writes still honoured.
- **r_reset low:** all latches 0, chg=0, state IDLE, all outputs 0.

## Timing
- start sampled at edge k.
- busy is high from after edge k through edge k+BEATS.
- Read: nibble i is valid on nib_out between edges k+1+i and k+2+i, for i = 0..BEATS-1.
- Write: nib_in sampled at edges k+1..k+BEATS. Latch updates at edge k+BEATS, and done is high for the following cycle.
- Back-to-back: a new start is accepted on the cycle done is high.
- lat_q and chg reflect a TI write one edge after ti_wr.
- err and done are each registered, exactly one cycle wide.

## Test plan
Defaults unless noted: DATA_W=8, NIB_W=4, NCH=4.
- **Reset:** r_reset low with start=1 and ti_wr=4'b1111 → lat_q=0, chg=0, busy/done/err/nib_oe=0. After release, IDLE.
- **Read:** ti_wr[1] with ti_d=8'hAA → chg=4'b0010. Then start, dir=0, ch_sel=1 → nib_out 4'hA on beats 0 and 1, nib_oe=1, done one cycle later, chg=0.
- **Write:** start, dir=1, ch_sel=2; nib_in 4'h5 then 4'hC → lat_q ch2=8'h5C after edge k+2, done=1, chg[2]=0.
- **Errors, NCH=3:** start with ch_sel=3 → err=1, busy stays 0. start during a read → err=1, and the read still completes with the correct nibbles.
- **Abort and collision:**
  - r_nibrst during beat 1 of a write to ch0 (latch 8'h11) → IDLE, lat ch0 stays 8'h11, no done.
  - Pi write 8'h5C to ch3 with ti_wr[3]=1, ti_d=8'h77 on the completion edge → lat ch3=8'h77, err=1, chg[3]=1.
- **Width, DATA_W=16:** ti writes 16'h1234 to ch0, then a Pi read → nibbles 1,2,3,4 on four consecutive cycles, done at k+4.
